// File: rtl/spt_abuf_req_if.sv
// rtl/spt_abuf_req_if.sv - SPORT autobuffer requester signal bundle
interface spt_abuf_req_if #(
    parameter int AW = 14
);
    logic          TABUF_EN;
    logic          RABUF_EN;
    logic          TX_empty;
    logic          RX_full;
    logic          T_Sack;
    logic          R_Sack;
    logic          reg_we;
    logic [2:0]    reg_sel;
    logic [AW-1:0] reg_di;
    logic          T_Sreqi;
    logic          R_Sreqi;
    logic [AW-1:0] T_addr;
    logic [AW-1:0] R_addr;
    logic          TX_ld;
    logic          RX_rel;
    logic          T_unf;
    logic          R_ovf;

    // Requester block view
    modport slave (
        input  TABUF_EN, RABUF_EN, TX_empty, RX_full, T_Sack, R_Sack,
        input  reg_we, reg_sel, reg_di,
        output T_Sreqi, R_Sreqi, T_addr, R_addr, TX_ld, RX_rel, T_unf, R_ovf
    );

    // SPORT / arbiter / register-host view
    modport master (
        output TABUF_EN, RABUF_EN, TX_empty, RX_full, T_Sack, R_Sack,
        output reg_we, reg_sel, reg_di,
        input  T_Sreqi, R_Sreqi, T_addr, R_addr, TX_ld, RX_rel, T_unf, R_ovf
    );
endinterface

// File: rtl/spt_abuf_req.sv
// rtl/spt_abuf_req.sv - SPORT autobuffer cycle-steal requester (TX and RX channels)
module spt_abuf_chan #(
    parameter int         AW       = 14,
    parameter logic [2:0] SEL_BASE = 3'd0
) (
    input  logic          DSPCLK,
    input  logic          T_RST,
    input  logic          en,
    input  logic          evt,
    input  logic          sack,
    input  logic          reg_we,
    input  logic [2:0]    reg_sel,
    input  logic [AW-1:0] reg_di,
    output logic          sreqi,
    output logic [AW-1:0] addr,
    output logic          done_pulse,
    output logic          err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] SEL_I = SEL_BASE;
    localparam logic [2:0] SEL_M = SEL_BASE + 3'd1;
    localparam logic [2:0] SEL_L = SEL_BASE + 3'd2;

    state_t        state_q, state_d;
    logic          again_q, again_d;
    logic          take;
    logic          set_err;
    logic [AW-1:0] i_q, m_q, l_q, b_q;
    logic [AW-1:0] sum;
    logic [AW:0]   limit;
    logic [AW-1:0] next_addr;
    logic          wr_i, wr_m, wr_l;

    assign wr_i = reg_we && (reg_sel == SEL_I);
    assign wr_m = reg_we && (reg_sel == SEL_M);
    assign wr_l = reg_we && (reg_sel == SEL_L);

    // Outputs decode straight from the state register, so they are glitch-free
    assign sreqi      = (state_q == ST_PEND);
    assign done_pulse = (state_q == ST_DONE);
    assign addr       = i_q;

    // Circular-buffer next address: wrap by L when stepping past either end
    always_comb begin
        sum       = i_q + m_q;
        limit     = {1'b0, b_q} + {1'b0, l_q};
        next_addr = sum;
        if (l_q != '0) begin
            if (!m_q[AW-1]) begin
                if ({1'b0, sum} >= limit) next_addr = sum - l_q;
            end else begin
                if (sum < b_q) next_addr = sum + l_q;
            end
        end
    end

    // Request state machine: next state, address-advance and overrun detection
    always_comb begin
        state_d = state_q;
        again_d = 1'b0;
        take    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (evt && en) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (sack) begin
                    // The granted cycle is honoured even if EN just dropped
                    state_d = ST_DONE;
                    take    = 1'b1;
                    again_d = evt && en;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end else if (evt) begin
                    set_err = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ((again_q || evt) && en) ? ST_PEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus the event seen during the granted cycle
    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            state_q <= ST_IDLE;
            again_q <= 1'b0;
        end else begin
            state_q <= state_d;
            again_q <= again_d;
        end
    end

    // Index/modify/length/base registers; a host write to I beats the auto-advance
    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            i_q <= '0;
            m_q <= '0;
            l_q <= '0;
            b_q <= '0;
        end else begin
            if (wr_i) begin
                i_q <= reg_di;
                b_q <= reg_di;
            end else if (take) begin
                i_q <= next_addr;
            end
            if (wr_m) m_q <= reg_di;
            if (wr_l) l_q <= reg_di;
        end
    end

    // Sticky overrun flag, cleared by re-arming the buffer through I
    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end else if (wr_i) begin
            err <= 1'b0;
        end
    end
endmodule

module spt_abuf_req #(
    parameter int AW = 14
) (
    input  logic           DSPCLK,
    input  logic           T_RST,
    spt_abuf_req_if.slave  bus
);
    spt_abuf_chan #(.AW(AW), .SEL_BASE(3'd0)) u_tx (
        .DSPCLK     (DSPCLK),
        .T_RST      (T_RST),
        .en         (bus.TABUF_EN),
        .evt        (bus.TX_empty),
        .sack       (bus.T_Sack),
        .reg_we     (bus.reg_we),
        .reg_sel    (bus.reg_sel),
        .reg_di     (bus.reg_di),
        .sreqi      (bus.T_Sreqi),
        .addr       (bus.T_addr),
        .done_pulse (bus.TX_ld),
        .err        (bus.T_unf)
    );

    spt_abuf_chan #(.AW(AW), .SEL_BASE(3'd3)) u_rx (
        .DSPCLK     (DSPCLK),
        .T_RST      (T_RST),
        .en         (bus.RABUF_EN),
        .evt        (bus.RX_full),
        .sack       (bus.R_Sack),
        .reg_we     (bus.reg_we),
        .reg_sel    (bus.reg_sel),
        .reg_di     (bus.reg_di),
        .sreqi      (bus.R_Sreqi),
        .addr       (bus.R_addr),
        .done_pulse (bus.RX_rel),
        .err        (bus.R_ovf)
    );
endmodule

// File: doc/spt_abuf_req.md
Name: spt_abuf_req

Overview:
- Requester side of the SPORT autobuffer cycle-steal protocol; one instance per SPORT.
- Turns SPORT transmit-buffer-empty and receive-buffer-full events into T_Sreqi/R_Sreqi requests for the steal arbiter.
- Holds each request until the arbiter's one-cycle Sack.
- Generates the DM address for each stolen cycle using circular-buffer modify/length arithmetic, and signals the SPORT to load TX or release RX once the transfer completes.

Parameters:
AW, 14, DM address / index / modify / length width.

Ports:
DSPCLK  input  1  system clock
T_RST  input  1  reset; synchronous, active-high
TABUF_EN  input  1  transmit autobuffer enable
RABUF_EN  input  1  receive autobuffer enable
TX_empty  input  1  one-cycle pulse: TX buffer emptied into shifter
RX_full  input  1  one-cycle pulse: RX buffer filled from shifter
T_Sack  input  1  arbiter grant for transmit request (one-cycle pulse)
R_Sack  input  1  arbiter grant for receive request (one-cycle pulse)
reg_we  input  1  register write strobe
reg_sel  input  3  0=TI,1=TM,2=TL,3=RI,4=RM,5=RL; 6,7 ignored
reg_di  input  AW  register write data
T_Sreqi  output  1  transmit steal request
R_Sreqi  output  1  receive steal request
T_addr  output  AW  current transmit DM address (TI)
R_addr  output  AW  current receive DM address (RI)
TX_ld  output  1  pulse: load TX from DMD
RX_rel  output  1  pulse: RX buffer consumed, SPORT may refill
T_unf  output  1  sticky transmit underflow
R_ovf  output  1  sticky receive overflow

Behaviour:
- All state updates on posedge DSPCLK. T_RST is synchronous and overrides everything else.
- Reset values:
  - Sreqi, TX_ld, RX_rel, T_unf, R_ovf = 0.
  - I, M, L, B registers = 0, so T_addr and R_addr = 0.
- Per-channel state machine, transmit and receive identical; x = T/R, event = TX_empty/RX_full:
  - IDLE: x_Sreqi=0. event && EN -> PEND.
  - PEND: x_Sreqi=1, registered. x_Sack -> DONE. event again while PEND -> stay PEND, set sticky flag (T_unf / R_ovf).
  - DONE: one cycle.
    - Transmit pulses TX_ld; receive pulses RX_rel.
    - I <= next address.
    - Go to PEND if an event arrived during the Sack cycle or this DONE cycle, else IDLE.
- Request latency: event at cycle n -> Sreqi=1 at n+1.
- Ack latency: Sack at cycle k -> Sreqi=0 at k+1; TX_ld/RX_rel=1 and I updated at k+1.
- Address: x_addr = I at all times. Address is valid throughout PEND and during the Sack cycle, since the arbiter steals that cycle.
- Sack in IDLE or DONE: ignored. It causes no update and no pulse.
- EN deasserted in PEND: next cycle -> IDLE, Sreqi=0.
  - A Sack arriving in that same cycle is honoured: -> DONE.
- Event with EN=0: ignored; no flag.
- Sticky flags clear only on T_RST, or on a write to the channel's I register.
- Register writes:
  - Writing I also loads base B <= reg_di.
  - Writes take effect next cycle.
  - A write to I in the same cycle as the DONE update wins over the computed next address.
- Circular next address (AW-bit, M two's complement, sum s = I+M modulo 2^AW):
  - L==0: next = s (linear, wraps mod 2^AW).
  - L!=0, M>=0: next = (s >= B+L) ? s-L : s.
  - L!=0, M<0: next = (s < B) ? s+L : s.
  - Correct only for |M| < L and B+L <= 2^AW. No detection of violation is required.
- Transmit and receive channels are fully independent. Simultaneous requests, acks and events on both channels are all legal.

Test Plan:
1. Reset, TI=0x100, TM=1, TL=4, TABUF_EN=1. Five TX_empty pulses, each acked 2 cycles after Sreqi -> T_addr sequence 0x100, 0x101, 0x102, 0x103, 0x100, 0x101. One TX_ld per ack. T_unf=0.
2. RI=0x203, RM=-1 (0x3FFF), RL=4. Three RX_full/R_Sack rounds -> R_addr 0x203, 0x202, 0x201, 0x200? No: B=0x203, so -1 from 0x203 gives 0x202 < B -> 0x206. Required sequence: 0x203, 0x206, 0x205, 0x204.
3. RX_full pulsed twice while R_Sreqi=1 and no ack -> R_ovf=1 and only one R_Sreqi. Write RI=0x0 -> R_ovf=0.
4. TX_empty in the same cycle as T_Sack -> TX_ld at k+1, T_Sreqi=1 again at k+2, T_unf=0.
5. TL=0, TM=1, TI=0x3FFF. One transfer -> T_addr=0x0000.
6. T_Sack while T_Sreqi=0 -> no TX_ld, T_addr unchanged. T_RST asserted in PEND -> T_Sreqi=0 next cycle, T_addr=0.
